// File: rtl/watchdog_timeout_handler_if.sv
// Watchdog handler signal bundle: time-out/acknowledge inputs and handler status outputs.
interface watchdog_timeout_handler_if #(
  parameter int GRACE_WIDTH = 8
);
  logic                   timeout;
  logic                   shutdown_ack;
  logic                   shutdown_req;
  logic                   force_stop;
  logic [1:0]             handler_state;
  logic [GRACE_WIDTH-1:0] grace_remaining;
  logic [7:0]             timeout_count;

  // Handler side
  modport slave (
    input  timeout,
    input  shutdown_ack,
    output shutdown_req,
    output force_stop,
    output handler_state,
    output grace_remaining,
    output timeout_count
  );

  // Environment side
  modport master (
    output timeout,
    output shutdown_ack,
    input  shutdown_req,
    input  force_stop,
    input  handler_state,
    input  grace_remaining,
    input  timeout_count
  );
endinterface

// File: rtl/watchdog_timeout_handler.sv
// Watchdog time-out handler: synchronizes the time-out level, requests a graceful
// shutdown on each rising edge and escalates to a sticky forced stop when the
// acknowledge does not arrive within the grace period.
module watchdog_timeout_handler #(
  parameter int GRACE_CYCLES = 100,
  parameter int GRACE_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  watchdog_timeout_handler_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    DONE   = 2'd2,
    FORCED = 2'd3
  } state_t;

  localparam logic [GRACE_WIDTH-1:0] GRACE_LOAD = GRACE_WIDTH'(GRACE_CYCLES);

  state_t                 state_q, state_d;
  logic [GRACE_WIDTH-1:0] grace_q, grace_d;
  logic [7:0]             count_q, count_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   prev_q, prev_d;
  logic                   rise;

  // Synchronizer, edge history and saturating edge counter next values
  always_comb begin
    sync1_d = bus.timeout;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;
    count_d = count_q;
    if (rise && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  // State register and all other flops, synchronous reset has priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grace_q <= '0;
      count_q <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grace_q <= grace_d;
      count_q <= count_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Next-state and grace counter logic; acknowledge wins over expiry in REQ
  always_comb begin
    state_d = state_q;
    grace_d = grace_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = REQ;
          grace_d = GRACE_LOAD;
        end
      end
      REQ: begin
        if (bus.shutdown_ack) begin
          state_d = DONE;
        end else if (grace_q == '0) begin
          state_d = FORCED;
        end else begin
          grace_d = grace_q - GRACE_WIDTH'(1);
        end
      end
      DONE: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end
      end
      FORCED: begin
        state_d = FORCED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.shutdown_req    = (state_q == REQ);
    bus.force_stop      = (state_q == FORCED);
    bus.handler_state   = state_q;
    bus.grace_remaining = grace_q;
    bus.timeout_count   = count_q;
  end

endmodule

// File: tb/tb_watchdog_timeout_handler.sv
// Testbench for watchdog_timeout_handler: directed scenarios plus a randomized
// run compared cycle by cycle against a deadline-based reference model.
module tb_watchdog_timeout_handler;

  localparam int G = 100;

  logic clk;
  logic reset;

  watchdog_timeout_handler_if #(.GRACE_WIDTH(8)) bus ();

  watchdog_timeout_handler #(
    .GRACE_CYCLES(G),
    .GRACE_WIDTH (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: pin history, mode, and the edge index at which the grace ends
  int m_edge;
  int m_mode;
  int m_deadline;
  int m_frozen;
  int m_cnt;
  int m_h [3];

  function automatic void model_step(input logic rst, input logic tout, input logic ack);
    int cur;
    bit rise_s;
    bit lvl;
    m_edge++;
    if (rst) begin
      m_mode   = 0;
      m_frozen = 0;
      m_cnt    = 0;
      m_h[0]   = 0;
      m_h[1]   = 0;
      m_h[2]   = 0;
    end else begin
      // synchronized level is the pin as seen two edges back; its previous one three back
      lvl    = (m_h[1] != 0);
      rise_s = (m_h[1] != 0) && (m_h[2] == 0);
      case (m_mode)
        0: if (rise_s) begin
             m_mode     = 1;
             m_deadline = m_edge + G;
           end
        1: begin
             cur = m_deadline - (m_edge - 1);
             if (ack) begin
               m_mode   = 2;
               m_frozen = cur;
             end else if (cur == 0) begin
               m_mode   = 3;
               m_frozen = 0;
             end
           end
        2: if (!lvl) m_mode = 0;
        default: ;
      endcase
      if (rise_s && m_cnt < 255) m_cnt++;
      m_h[2] = m_h[1];
      m_h[1] = m_h[0];
      m_h[0] = tout ? 1 : 0;
    end
  endfunction

  function automatic int model_grace();
    return (m_mode == 1) ? (m_deadline - m_edge) : m_frozen;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.timeout      = 1'b0;
    bus.shutdown_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!bus.shutdown_req && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.timeout      = 1'b1;
    bus.shutdown_ack = 1'b1;
    tick();
    tick();
    total_cnt++; if (bus.handler_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", bus.handler_state); else pass_cnt++;
    total_cnt++; if (bus.shutdown_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.shutdown_req); else pass_cnt++;
    total_cnt++; if (bus.force_stop !== 1'b0) $display("FAIL reset_force: got %b want 0", bus.force_stop); else pass_cnt++;
    total_cnt++; if (bus.grace_remaining !== 8'd0) $display("FAIL reset_grace: got %0d want 0", bus.grace_remaining); else pass_cnt++;
    total_cnt++; if (bus.timeout_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", bus.timeout_count); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_no_ack();
    int first_req = -1;
    int req_cycles = 0;
    int bad = 0;
    do_reset();
    bus.timeout = 1'b1;
    for (int i = 1; i <= 250; i++) begin
      tick();
      if (bus.shutdown_req) begin
        if (first_req < 0) first_req = i;
        req_cycles++;
      end
      if (bus.force_stop) break;
    end
    total_cnt++; if (first_req !== 3) $display("FAIL noack_latency: got %0d want 3", first_req); else pass_cnt++;
    total_cnt++; if (req_cycles !== G + 1) $display("FAIL noack_req_cycles: got %0d want %0d", req_cycles, G + 1); else pass_cnt++;
    total_cnt++; if (bus.force_stop !== 1'b1) $display("FAIL noack_force: got %b want 1", bus.force_stop); else pass_cnt++;
    total_cnt++; if (bus.handler_state !== 2'd3) $display("FAIL noack_state: got %0d want 3", bus.handler_state); else pass_cnt++;
    total_cnt++; if (bus.timeout_count !== 8'd1) $display("FAIL noack_count: got %0d want 1", bus.timeout_count); else pass_cnt++;
    total_cnt++; if (bus.grace_remaining !== 8'd0) $display("FAIL noack_grace: got %0d want 0", bus.grace_remaining); else pass_cnt++;
    // FORCED is terminal: ack and time-out activity cannot leave it
    for (int i = 0; i < 40; i++) begin
      bus.shutdown_ack = 1'($urandom_range(0, 1));
      bus.timeout      = 1'(i / 8 % 2 == 0);
      tick();
      if (bus.handler_state !== 2'd3 || bus.shutdown_req !== 1'b0) bad++;
    end
    total_cnt++; if (bad !== 0) $display("FAIL forced_terminal: got %0d bad cycles want 0", bad); else pass_cnt++;
  endtask

  task automatic test_ack_mid();
    int n;
    do_reset();
    bus.timeout = 1'b1;
    wait_req(n);
    total_cnt++; if (n !== 3) $display("FAIL ackmid_latency: got %0d want 3", n); else pass_cnt++;
    for (int i = 0; i < 4; i++) tick();
    total_cnt++; if (bus.grace_remaining !== 8'(G - 4)) $display("FAIL ackmid_grace5: got %0d want %0d", bus.grace_remaining, G - 4); else pass_cnt++;
    bus.shutdown_ack = 1'b1;
    tick();
    bus.shutdown_ack = 1'b0;
    total_cnt++; if (bus.handler_state !== 2'd2) $display("FAIL ackmid_done: got %0d want 2", bus.handler_state); else pass_cnt++;
    total_cnt++; if (bus.grace_remaining !== 8'd96) $display("FAIL ackmid_grace: got %0d want 96", bus.grace_remaining); else pass_cnt++;
    total_cnt++; if (bus.force_stop !== 1'b0) $display("FAIL ackmid_force: got %b want 0", bus.force_stop); else pass_cnt++;
    tick();
    total_cnt++; if (bus.handler_state !== 2'd2) $display("FAIL ackmid_hold: got %0d want 2", bus.handler_state); else pass_cnt++;
    bus.timeout = 1'b0;
    tick();
    tick();
    total_cnt++; if (bus.handler_state !== 2'd2) $display("FAIL ackmid_fall_early: got %0d want 2", bus.handler_state); else pass_cnt++;
    tick();
    total_cnt++; if (bus.handler_state !== 2'd0) $display("FAIL ackmid_idle: got %0d want 0", bus.handler_state); else pass_cnt++;
    total_cnt++; if (bus.grace_remaining !== 8'd96) $display("FAIL ackmid_idle_grace: got %0d want 96", bus.grace_remaining); else pass_cnt++;
  endtask

  task automatic test_ack_at_zero();
    int n;
    do_reset();
    bus.timeout = 1'b1;
    wait_req(n);
    for (int i = 0; i < G; i++) tick();
    total_cnt++; if (bus.grace_remaining !== 8'd0 || bus.shutdown_req !== 1'b1) $display("FAIL ackzero_pre: got grace %0d req %b want 0 1", bus.grace_remaining, bus.shutdown_req); else pass_cnt++;
    bus.shutdown_ack = 1'b1;
    tick();
    bus.shutdown_ack = 1'b0;
    total_cnt++; if (bus.handler_state !== 2'd2) $display("FAIL ackzero_state: got %0d want 2", bus.handler_state); else pass_cnt++;
    total_cnt++; if (bus.force_stop !== 1'b0) $display("FAIL ackzero_force: got %b want 0", bus.force_stop); else pass_cnt++;
  endtask

  task automatic test_reset_mid_req();
    int n;
    do_reset();
    bus.timeout = 1'b1;
    wait_req(n);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    total_cnt++; if ({bus.shutdown_req, bus.force_stop, bus.handler_state} !== 4'b0) $display("FAIL rstmid_ctrl: got %b want 0000", {bus.shutdown_req, bus.force_stop, bus.handler_state}); else pass_cnt++;
    total_cnt++; if (bus.grace_remaining !== 8'd0 || bus.timeout_count !== 8'd0) $display("FAIL rstmid_cnts: got grace %0d count %0d want 0 0", bus.grace_remaining, bus.timeout_count); else pass_cnt++;
    reset = 1'b0;
    wait_req(n);
    total_cnt++; if (n !== 3) $display("FAIL rstmid_latency: got %0d want 3", n); else pass_cnt++;
    total_cnt++; if (bus.timeout_count !== 8'd1) $display("FAIL rstmid_count: got %0d want 1", bus.timeout_count); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int bad = 0;
    do_reset();
    bus.shutdown_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.handler_state !== 2'd0 || bus.shutdown_req !== 1'b0) bad++;
    end
    total_cnt++; if (bad !== 0) $display("FAIL idle_ack: got %0d bad cycles want 0", bad); else pass_cnt++;
    for (int t = 1; t <= 300; t++) begin
      bus.timeout = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      bus.timeout = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      if (t == 100) begin
        total_cnt++; if (bus.timeout_count !== 8'd100) $display("FAIL sat_100: got %0d want 100", bus.timeout_count); else pass_cnt++;
      end
      if (t == 255) begin
        total_cnt++; if (bus.timeout_count !== 8'd255) $display("FAIL sat_255: got %0d want 255", bus.timeout_count); else pass_cnt++;
      end
    end
    total_cnt++; if (bus.timeout_count !== 8'd255) $display("FAIL sat_300: got %0d want 255", bus.timeout_count); else pass_cnt++;
    bus.shutdown_ack = 1'b0;
  endtask

  task automatic test_random();
    logic c_rst, c_tout, c_ack;
    int hold = 0;
    int ack_rate = 10;
    m_edge = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      reset = (cyc < 2) || ($urandom_range(0, 399) == 0);
      if (hold == 0) begin
        bus.timeout = ~bus.timeout;
        hold = ($urandom_range(0, 5) == 0) ? int'($urandom_range(100, 160)) : int'($urandom_range(1, 20));
      end
      hold--;
      if (cyc % 200 == 0) ack_rate = int'($urandom_range(0, 20));
      bus.shutdown_ack = (ack_rate != 0) && ($urandom_range(1, 200) <= ack_rate);
      c_rst  = reset;
      c_tout = bus.timeout;
      c_ack  = bus.shutdown_ack;
      tick();
      model_step(c_rst, c_tout, c_ack);
      total_cnt++; if (bus.handler_state !== 2'(m_mode)) $display("FAIL rnd_state cyc%0d: got %0d want %0d", cyc, bus.handler_state, m_mode); else pass_cnt++;
      total_cnt++; if (bus.shutdown_req !== (m_mode == 1)) $display("FAIL rnd_req cyc%0d: got %b want %b", cyc, bus.shutdown_req, m_mode == 1); else pass_cnt++;
      total_cnt++; if (bus.force_stop !== (m_mode == 3)) $display("FAIL rnd_force cyc%0d: got %b want %b", cyc, bus.force_stop, m_mode == 3); else pass_cnt++;
      total_cnt++; if (bus.grace_remaining !== 8'(model_grace())) $display("FAIL rnd_grace cyc%0d: got %0d want %0d", cyc, bus.grace_remaining, model_grace()); else pass_cnt++;
      total_cnt++; if (bus.timeout_count !== 8'(m_cnt)) $display("FAIL rnd_count cyc%0d: got %0d want %0d", cyc, bus.timeout_count, m_cnt); else pass_cnt++;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    bus.timeout      = 1'b0;
    bus.shutdown_ack = 1'b0;
    test_reset();
    test_no_ack();
    test_ack_mid();
    test_ack_at_zero();
    test_reset_mid_req();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
